// File: rtl/text_mode_pipeline_pkg.sv
// Shared constants, character/colour types and VRAM addressing helper
// for the text-mode renderer.
package text_mode_pkg;

  localparam int DEF_COLS           = 80;
  localparam int DEF_ROWS           = 30;
  localparam int DEF_CHAR_W         = 8;
  localparam int DEF_CHAR_H         = 16;
  localparam int DEF_CHARS_PER_WORD = 2;
  localparam int DEF_PAL_SIZE       = 16;
  localparam int DEF_BLINK_FRAMES   = 30;

  localparam int VRAM_AW = $clog2(DEF_ROWS * DEF_COLS / DEF_CHARS_PER_WORD);
  // 128 glyph codes, CHAR_H rows each
  localparam int FONT_AW = $clog2(128 * DEF_CHAR_H);
  localparam int FONT_W  = DEF_CHAR_W;

  typedef struct packed {
    logic       invert;
    logic [6:0] glyph;
    logic [3:0] fg;
    logic [3:0] bg;
  } char_attr_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic logic [VRAM_AW-1:0] vram_index(
    input int unsigned row,
    input int unsigned col,
    input int unsigned words_per_row  = DEF_COLS / DEF_CHARS_PER_WORD,
    input int unsigned chars_per_word = DEF_CHARS_PER_WORD
  );
    int unsigned idx;
    idx = row * words_per_row + col / chars_per_word;
    return idx[VRAM_AW-1:0];
  endfunction

endpackage

// File: rtl/text_mode_pipeline_if.sv
// Memory-side bus of the renderer: VRAM and font ROM, both with 1-cycle
// synchronous read data.
interface text_mode_pipeline_if;
  import text_mode_pkg::*;

  logic [VRAM_AW-1:0] vram_addr;
  logic [31:0]        vram_rdata;
  logic [FONT_AW-1:0] font_addr;
  logic [FONT_W-1:0]  font_data;

  modport master (
    output vram_addr,
    output font_addr,
    input  vram_rdata,
    input  font_data
  );

  modport slave (
    input  vram_addr,
    input  font_addr,
    output vram_rdata,
    output font_data
  );
endinterface

// File: rtl/text_mode_pipeline_cursor_blink.sv
// Cursor blink timebase: counts vsync rising edges and toggles the blink
// phase every BLINK_FRAMES edges.
module cursor_blink #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic blink_phase
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          vsync_q;
  logic          vsync_rise;
  logic [CW-1:0] frame_cnt;

  assign vsync_rise = vsync & ~vsync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (vsync_rise) begin
        if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/text_mode_pipeline.sv
// Three-stage text-mode renderer: cell/VRAM address, glyph/font fetch,
// pixel colour resolve; RGB and syncs come out exactly 3 cycles after input.
module text_mode_pipeline
  import text_mode_pkg::*;
#(
  parameter int COLS           = DEF_COLS,
  parameter int ROWS           = DEF_ROWS,
  parameter int CHAR_W         = DEF_CHAR_W,
  parameter int CHAR_H         = DEF_CHAR_H,
  parameter int CHARS_PER_WORD = DEF_CHARS_PER_WORD,
  parameter int PAL_SIZE       = DEF_PAL_SIZE,
  parameter int BLINK_FRAMES   = DEF_BLINK_FRAMES
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   vde_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  text_mode_pipeline_if.master   mem,
  input  logic [PAL_SIZE*12-1:0] palette,
  input  logic                   cursor_en,
  input  logic [6:0]             cursor_col,
  input  logic [4:0]             cursor_row,
  output logic [3:0]             Red,
  output logic [3:0]             Green,
  output logic [3:0]             Blue,
  output logic                   vde_out,
  output logic                   hsync_out,
  output logic                   vsync_out
);

  localparam int X_SHIFT = $clog2(CHAR_W);
  localparam int Y_SHIFT = $clog2(CHAR_H);
  localparam int SEL_W   = (CHARS_PER_WORD > 1) ? $clog2(CHARS_PER_WORD) : 1;
  localparam int PIDX_W  = $clog2(PAL_SIZE);

  // S0: cell coordinates and VRAM address
  logic [9:0]       cell_col;
  logic [9:0]       cell_row;
  logic             outside;
  logic             hit;

  assign cell_col = DrawX >> X_SHIFT;
  assign cell_row = DrawY >> Y_SHIFT;
  assign outside  = (DrawX >= 10'(COLS * CHAR_W)) || (DrawY >= 10'(ROWS * CHAR_H));
  assign hit      = cursor_en && !outside &&
                    (cell_col == {3'b0, cursor_col}) && (cell_row == {5'b0, cursor_row});
  assign mem.vram_addr = outside ? '0 :
         vram_index(32'(cell_row), 32'(cell_col), COLS / CHARS_PER_WORD, CHARS_PER_WORD);

  logic [SEL_W-1:0]   s1_sel;
  logic [Y_SHIFT-1:0] s1_prow, s2_prow;
  logic [X_SHIFT-1:0] s1_pcol, s2_pcol;
  logic               s1_hit, s1_outside, s1_vde, s1_hs, s1_vs;
  logic               s2_hit, s2_outside, s2_vde, s2_hs, s2_vs;
  char_attr_t         s1_attr, s2_attr;
  rgb444_t            s2_color, rgb_q;
  logic               s2_bit, s2_on, blink_phase;
  logic [PIDX_W-1:0]  pal_idx;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_sel     <= '0;
      s1_prow    <= '0;
      s1_pcol    <= '0;
      s1_hit     <= 1'b0;
      s1_outside <= 1'b0;
      s1_vde     <= 1'b0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
    end else begin
      s1_sel     <= cell_col[SEL_W-1:0];
      s1_prow    <= DrawY[Y_SHIFT-1:0];
      s1_pcol    <= DrawX[X_SHIFT-1:0];
      s1_hit     <= hit;
      s1_outside <= outside;
      s1_vde     <= vde_in;
      s1_hs      <= hsync_in;
      s1_vs      <= vsync_in;
    end
  end

  // S1: halfword select (lowest halfword = leftmost column) and font address
  assign s1_attr       = char_attr_t'(mem.vram_rdata[32'(s1_sel) * 16 +: 16]);
  assign mem.font_addr = FONT_AW'(32'(s1_attr.glyph) * CHAR_H + 32'(s1_prow));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s2_attr    <= '0;
      s2_prow    <= '0;
      s2_pcol    <= '0;
      s2_hit     <= 1'b0;
      s2_outside <= 1'b0;
      s2_vde     <= 1'b0;
      s2_hs      <= 1'b0;
      s2_vs      <= 1'b0;
    end else begin
      s2_attr    <= s1_attr;
      s2_prow    <= s1_prow;
      s2_pcol    <= s1_pcol;
      s2_hit     <= s1_hit;
      s2_outside <= s1_outside;
      s2_vde     <= s1_vde;
      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
    end
  end

  cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_cursor_blink (
    .clk        (Clk),
    .rst        (Reset),
    .vsync      (vsync_in),
    .blink_phase(blink_phase)
  );

  // S2: bit 7 of the font row is the leftmost pixel; cursor is an underline
  // on the bottom two pixel rows of the cell
  assign s2_bit   = mem.font_data[X_SHIFT'(CHAR_W - 1) - s2_pcol];
  assign s2_on    = s2_bit ^ s2_attr.invert ^
                    (s2_hit & blink_phase & (s2_prow >= Y_SHIFT'(CHAR_H - 2)));
  assign pal_idx  = s2_on ? s2_attr.fg : s2_attr.bg;
  assign s2_color = rgb444_t'(palette[32'(pal_idx) * 12 +: 12]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_q     <= '0;
      vde_out   <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb_q     <= (s2_vde && !s2_outside) ? s2_color : '0;
      vde_out   <= s2_vde;
      hsync_out <= s2_hs;
      vsync_out <= s2_vs;
    end
  end

  assign Red   = rgb_q.r;
  assign Green = rgb_q.g;
  assign Blue  = rgb_q.b;

endmodule

// File: tb/tb_text_mode_pipeline.sv
// Directed bench for text_mode_pipeline: vector table for addressing,
// pixel bits, invert, blanking and sync delay; sequences for reset and blink.
module tb_text_mode_pipeline;
  import text_mode_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    draw_x, draw_y;
  logic          vde_in, hsync_in, vsync_in;
  logic [191:0]  palette;
  logic          cursor_en;
  logic [6:0]    cursor_col;
  logic [4:0]    cursor_row;
  logic [3:0]    red, green, blue;
  logic          vde_out, hsync_out, vsync_out;
  logic [31:0]   vram [0:2047];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vde;
    logic        hs;
    logic        vs;
    logic [10:0] addr;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[$];

  text_mode_pipeline_if bus();

  text_mode_pipeline dut (
    .Clk       (clk),
    .Reset     (rst),
    .DrawX     (draw_x),
    .DrawY     (draw_y),
    .vde_in    (vde_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .mem       (bus),
    .palette   (palette),
    .cursor_en (cursor_en),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .Red       (red),
    .Green     (green),
    .Blue      (blue),
    .vde_out   (vde_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.vram_rdata <= vram[bus.vram_addr];
    bus.font_data  <= 8'hF0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] rgb_now();
    return {red, green, blue};
  endfunction

  task automatic add(input logic [9:0] x, input logic [9:0] y, input logic vde,
                     input logic hs, input logic vs, input logic [10:0] addr,
                     input logic [11:0] rgb);
    vec_t v;
    v.x = x; v.y = y; v.vde = vde; v.hs = hs; v.vs = vs; v.addr = addr; v.rgb = rgb;
    vecs.push_back(v);
  endtask

  task automatic set_pal(input int idx, input logic [11:0] c);
    palette[idx*12 +: 12] = c;
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, output logic [11:0] rgb);
    @(posedge clk); #1;
    draw_x = x; draw_y = y; vde_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rgb = rgb_now();
    vde_in = 1'b0;
  endtask

  task automatic vpulse();
    @(posedge clk); #1 vsync_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 vsync_in = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    logic [11:0] c;
    for (int i = 0; i < 2048; i++) vram[i] = 32'h0;
    vram[0]    = 32'h0000_4112;
    vram[40]   = 32'h4221_0000;
    vram[80]   = 32'h0000_C112;
    vram[1199] = 32'h0323_0000;
    palette = '0;
    set_pal(0, 12'h0A0);
    set_pal(1, 12'hF00);
    set_pal(2, 12'h00F);
    set_pal(3, 12'h123);
    cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0;
    draw_x = 10'd0; draw_y = 10'd0;
    vde_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;

    // held in reset with live video
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(rgb_now()), 32'h0);
    chk("rst_vde", 32'(vde_out), 32'h0);
    chk("rst_hs", 32'(hsync_out), 32'h0);
    chk("rst_addr", 32'(bus.vram_addr), 32'h0);

    // release: first valid pixel 3 cycles later
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rel_rgb_%0d", k), 32'(rgb_now()), (k == 3) ? 32'hF00 : 32'h0);
      chk($sformatf("rel_vde_%0d", k), 32'(vde_out), (k == 3) ? 32'h1 : 32'h0);
    end
    chk("rel_hs", 32'(hsync_out), 32'h1);

    // mid-line reset clears outputs immediately
    #1 rst = 1'b1;
    #1;
    chk("mid_rgb", 32'(rgb_now()), 32'h0);
    chk("mid_vde", 32'(vde_out), 32'h0);
    chk("mid_hs", 32'(hsync_out), 32'h0);
    chk("mid_vs", 32'(vsync_out), 32'h0);
    vsync_in = 1'b0; hsync_in = 1'b0; vde_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    add(10'd0,    10'd0,    1, 1, 0, 11'd0,    12'hF00);
    add(10'd1,    10'd0,    1, 0, 0, 11'd0,    12'hF00);
    add(10'd2,    10'd0,    1, 1, 1, 11'd0,    12'hF00);
    add(10'd3,    10'd0,    1, 0, 1, 11'd0,    12'hF00);
    add(10'd4,    10'd0,    1, 0, 0, 11'd0,    12'h00F);
    add(10'd5,    10'd0,    1, 1, 0, 11'd0,    12'h00F);
    add(10'd6,    10'd0,    1, 0, 0, 11'd0,    12'h00F);
    add(10'd7,    10'd0,    1, 0, 1, 11'd0,    12'h00F);
    add(10'd8,    10'd0,    1, 0, 0, 11'd0,    12'h0A0);
    add(10'd16,   10'd0,    1, 1, 1, 11'd1,    12'h0A0);
    add(10'd8,    10'd16,   1, 0, 0, 11'd40,   12'h00F);
    add(10'd12,   10'd16,   1, 0, 0, 11'd40,   12'hF00);
    add(10'd15,   10'd16,   1, 1, 0, 11'd40,   12'hF00);
    add(10'd0,    10'd32,   1, 0, 0, 11'd80,   12'h00F);
    add(10'd4,    10'd32,   1, 0, 1, 11'd80,   12'hF00);
    add(10'd7,    10'd32,   1, 0, 0, 11'd80,   12'hF00);
    add(10'd632,  10'd479,  1, 1, 0, 11'd1199, 12'h00F);
    add(10'd639,  10'd479,  1, 0, 0, 11'd1199, 12'h123);
    add(10'd640,  10'd0,    1, 1, 1, 11'd0,    12'h000);
    add(10'd0,    10'd480,  1, 0, 1, 11'd0,    12'h000);
    add(10'd1023, 10'd1023, 1, 0, 0, 11'd0,    12'h000);
    add(10'd0,    10'd0,    0, 1, 0, 11'd0,    12'h000);
    add(10'd4,    10'd0,    0, 0, 1, 11'd0,    12'h000);
    add(10'd0,    10'd0,    1, 0, 0, 11'd0,    12'hF00);

    for (int i = 0; i < vecs.size() + 3; i++) begin
      @(posedge clk); #1;
      if (i >= 3) begin
        chk($sformatf("v%0d_rgb", i - 3), 32'(rgb_now()), 32'(vecs[i-3].rgb));
        chk($sformatf("v%0d_vde", i - 3), 32'(vde_out), 32'(vecs[i-3].vde));
        chk($sformatf("v%0d_hs", i - 3), 32'(hsync_out), 32'(vecs[i-3].hs));
        chk($sformatf("v%0d_vs", i - 3), 32'(vsync_out), 32'(vecs[i-3].vs));
      end
      if (i < vecs.size()) begin
        draw_x = vecs[i].x; draw_y = vecs[i].y;
        vde_in = vecs[i].vde; hsync_in = vecs[i].hs; vsync_in = vecs[i].vs;
        #1 chk($sformatf("v%0d_addr", i), 32'(bus.vram_addr), 32'(vecs[i].addr));
      end else begin
        draw_x = 10'd0; draw_y = 10'd0;
        vde_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      end
    end

    // font address = glyph*16 + pixel row, one cycle after the pixel
    @(posedge clk); #1 draw_x = 10'd0; draw_y = 10'd5; vde_in = 1'b1;
    @(posedge clk); #1 chk("font_addr_r5", 32'(bus.font_addr), 32'd1045);
    draw_x = 10'd8; draw_y = 10'd16;
    @(posedge clk); #1 chk("font_addr_odd", 32'(bus.font_addr), 32'd1056);
    draw_x = 10'd3; draw_y = 10'd0;
    @(posedge clk); #1 chk("font_addr_r0", 32'(bus.font_addr), 32'd1040);
    vde_in = 1'b0;

    // cursor blink from a fresh reset
    vsync_in = 1'b0; hsync_in = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cursor_en = 1'b1; cursor_col = 7'd0; cursor_row = 5'd0;
    repeat (29) vpulse();
    probe(10'd0, 10'd15, c); chk("blink_29", 32'(c), 32'hF00);
    vpulse();
    probe(10'd0, 10'd15, c); chk("blink_30_r15", 32'(c), 32'h00F);
    probe(10'd0, 10'd14, c); chk("blink_30_r14", 32'(c), 32'h00F);
    probe(10'd0, 10'd13, c); chk("blink_30_r13", 32'(c), 32'hF00);
    cursor_col = 7'd1;
    probe(10'd0, 10'd15, c); chk("blink_other_col", 32'(c), 32'hF00);
    cursor_col = 7'd0; cursor_en = 1'b0;
    probe(10'd0, 10'd15, c); chk("blink_disabled", 32'(c), 32'hF00);
    cursor_en = 1'b1;
    repeat (29) vpulse();
    probe(10'd0, 10'd15, c); chk("blink_59", 32'(c), 32'h00F);
    vpulse();
    probe(10'd0, 10'd15, c); chk("blink_60", 32'(c), 32'hF00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
